accum_feeder: RTL and testbench

Sample sequencer that drives the accumulator's `A`/`n` input interface. It buffers a batch of `COUNT` words written by a host and streams them back-to-back, one per clock, with the matching index on `n`. The final word carries `n = COUNT-1`, so the downstream accumulator captures its total on that cycle. `accum_feeder` sits between the host/register side and the accumulator, and signals batch completion with `done`.

---
 rtl/accum_feeder.sv | 117 +++++++++++
 tb/tb_accum_feeder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/accum_feeder.sv
// Buffers a batch of COUNT host words and streams them to the accumulator A/n port, one per clock.
// Optional feature: define ACCUM_FEEDER_REPLAY_EN to retain the batch after DONE for replay.
module accum_feeder #(
  parameter int WIDTH = 32,
  parameter int COUNT = 10,
  parameter int NW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  output logic [WIDTH-1:0] A,
  output logic [NW-1:0]    n,
  output logic             a_valid,
  output logic             full,
  output logic             busy,
  output logic             done
);

  localparam logic [NW:0]   COUNT_L = (NW+1)'(COUNT);
  localparam logic [NW:0]   ONE_L   = (NW+1)'(1);
  localparam logic [NW-1:0] LAST_L  = NW'(COUNT-1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state_r;
  logic [NW:0]      wp_r;
  logic [NW:0]      rp_r;
  logic [WIDTH-1:0] mem_r [COUNT];
  logic             wr_s;

  // Host writes are accepted only while idle and the buffer still has room
  always_comb begin
    if ((state_r == IDLE) && wr_en && !full) begin
      wr_s = 1'b1;
    end else begin
      wr_s = 1'b0;
    end
  end

  // Batch storage; contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wp_r[NW-1:0]] <= wr_data;
    end
  end

  // Sequencer FSM with registered stream outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      wp_r    <= {(NW+1){1'b0}};
      rp_r    <= {(NW+1){1'b0}};
      A       <= {WIDTH{1'b0}};
      n       <= {NW{1'b0}};
      a_valid <= 1'b0;
      full    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (wr_s) begin
            wp_r <= wp_r + ONE_L;
            full <= ((wp_r + ONE_L) == COUNT_L);
          end
          // Word 0 goes out on the same edge that samples start
          if (start && full) begin
            state_r <= STREAM;
            A       <= mem_r[0];
            n       <= {NW{1'b0}};
            a_valid <= 1'b1;
            busy    <= 1'b1;
            rp_r    <= ONE_L;
          end
        end
        STREAM: begin
          if (n == LAST_L) begin
            state_r <= DONE;
            done    <= 1'b1;
            a_valid <= 1'b0;
            A       <= {WIDTH{1'b0}};
            n       <= {NW{1'b0}};
            rp_r    <= {(NW+1){1'b0}};
`ifndef ACCUM_FEEDER_REPLAY_EN
            wp_r    <= {(NW+1){1'b0}};
            full    <= 1'b0;
`endif
          end else begin
            A    <= mem_r[rp_r[NW-1:0]];
            n    <= rp_r[NW-1:0];
            rp_r <= rp_r + ONE_L;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          A       <= {WIDTH{1'b0}};
          n       <= {NW{1'b0}};
          a_valid <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_feeder.sv
// Scoreboard bench for accum_feeder: stimulus queues expected words/done, a negedge monitor checks them.
module tb_accum_feeder;
  localparam int WIDTH = 32;
  localparam int COUNT = 10;
  localparam int NW    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] A;
  logic [NW-1:0]    n;
  logic             a_valid, full, busy, done;

  accum_feeder #(.WIDTH(WIDTH), .COUNT(COUNT), .NW(NW)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .A(A), .n(n), .a_valid(a_valid), .full(full), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_done;
    logic [63:0] val;
    logic [NW-1:0] idx;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] acc = 64'd0;
  logic [WIDTH-1:0] exp_mem [COUNT];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pops one expectation per presented word or done pulse
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      acc = 64'd0;
    end else if (a_valid || done) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_output: got A=%0h n=%0d done=%b required no output", A, n, done);
      end else begin
        e = q.pop_front();
        chk("done_flag", {63'd0, done}, {63'd0, e.is_done});
        if (e.is_done) begin
          chk("done_a_valid", {63'd0, a_valid}, 64'd0);
          chk("accum_total", acc, e.val);
          acc = 64'd0;
        end else begin
          chk("stream_A", {32'd0, A}, e.val);
          chk("stream_n", {60'd0, n}, {60'd0, e.idx});
          acc = acc + {32'd0, A};
        end
      end
    end else begin
      chk("idle_A", {32'd0, A}, 64'd0);
      chk("idle_n", {60'd0, n}, 64'd0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    wr_en = 1'b1;
    wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [WIDTH-1:0] base, input logic inc);
    for (int i = 0; i < COUNT; i++) begin
      exp_mem[i] = inc ? base + WIDTH'(i) : base;
      write_word(exp_mem[i]);
    end
  endtask

  task automatic do_start(input logic expect_stream, input logic [63:0] sum);
    exp_t e;
    if (expect_stream) begin
      for (int i = 0; i < COUNT; i++) begin
        e.is_done = 1'b0;
        e.val = {32'd0, exp_mem[i]};
        e.idx = NW'(i);
        q.push_back(e);
      end
      e.is_done = 1'b1;
      e.val = sum;
      e.idx = '0;
      q.push_back(e);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40; k++) begin
      if (!busy) break;
      cyc();
    end
    if (busy) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got busy=1 required busy=0 within 40 cycles");
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_A"}, {32'd0, A}, 64'd0);
    chk({tag, "_n"}, {60'd0, n}, 64'd0);
    chk({tag, "_a_valid"}, {63'd0, a_valid}, 64'd0);
    chk({tag, "_full"}, {63'd0, full}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int k;
    // Power-on reset
    repeat (2) cyc();
    check_zero_outputs("por");
    reset = 1'b0;
    repeat (2) cyc();

    // Asynchronous reset asserted mid-cycle, then a start that must do nothing
    write_word(32'h1234);
    #2 reset = 1'b1;
    #1 check_zero_outputs("async_rst");
    cyc();
    reset = 1'b0;
    do_start(1'b0, 64'd0);
    chk("start_after_reset_busy", {63'd0, busy}, 64'd0);

    // Nine words: not full, start ignored
    for (int i = 0; i < COUNT - 1; i++) begin
      exp_mem[i] = WIDTH'(i + 1);
      write_word(exp_mem[i]);
    end
    chk("full_after_9", {63'd0, full}, 64'd0);
    do_start(1'b0, 64'd0);
    chk("busy_after_start_9", {63'd0, busy}, 64'd0);
    exp_mem[COUNT-1] = 32'd10;
    write_word(exp_mem[COUNT-1]);
    chk("full_after_10", {63'd0, full}, 64'd1);
    write_word(32'd99);
    chk("full_after_11", {63'd0, full}, 64'd1);

    // Stream 1..10, poke wr_en/start mid-stream
    do_start(1'b1, 64'd55);
    chk("busy_in_stream", {63'd0, busy}, 64'd1);
    cyc();
    wr_en = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    start = 1'b1;
    cyc();
    wr_en = 1'b0;
    start = 1'b0;
    wait_idle();

`ifdef ACCUM_FEEDER_REPLAY_EN
    chk("full_after_done", {63'd0, full}, 64'd1);
    do_start(1'b1, 64'd55);
    wait_idle();
`else
    chk("full_after_done", {63'd0, full}, 64'd0);
    do_start(1'b0, 64'd0);
    chk("busy_second_start", {63'd0, busy}, 64'd0);
    load(32'd1, 1'b1);
`endif

    // Mid-stream abort at n=4
    do_start(1'b1, 64'd55);
    for (k = 0; k < 20; k++) begin
      if (a_valid && n == 4'd4) break;
      cyc();
    end
    chk("reached_n4", {63'd0, (a_valid && n == 4'd4)}, 64'd1);
    #2 reset = 1'b1;
    q.delete();
    #1 check_zero_outputs("abort");
    cyc();
    reset = 1'b0;
    cyc();

    // Reload all-ones and stream bit-exact
    load(32'hFFFF_FFFF, 1'b0);
    chk("full_ones", {63'd0, full}, 64'd1);
    do_start(1'b1, 64'h9_FFFF_FFF6);
    wait_idle();
    repeat (3) cyc();
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
